alarm_set_ctrl: RTL
===================

# alarm_set_ctrl

User-setting controller for the digital alarm clock. It takes the synchronized MODE, UP and DOWN button levels, converts them to single-cycle press events and steps a mode state machine through time-set and alarm-set fields. It holds the edited time and the alarm time. It hands a new time to the timekeeper with a one-cycle load pulse. It sits between the button synchronizers and the timekeeper/display mux.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 30_000_000: idle cycles in any set state before abandoning the edit.
- `HOLD_CYC`, default 10_000_000: cycles UP/DOWN must be held before auto-repeat starts (only with `AUTO_REPEAT_EN`).
- `REPEAT_CYC`, default 2_500_000: cycles between auto-repeat steps (only with `AUTO_REPEAT_EN`).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `btn_mode`, `btn_up`, `btn_down` in 1 each: synchronized button levels, high = pressed.
- `cur_hr` in 5: timekeeper hours, 0–23.
- `cur_min` in 6: timekeeper minutes, 0–59.
- `mode` out 3: current state encoding.
- `blink_hr`, `blink_min` out 1 each: the field being edited.
- `set_hr` out 5, `set_min` out 6: edit registers.
- `time_load` out 1: one-cycle pulse that loads `set_hr`/`set_min` into the timekeeper.
- `alm_hr` out 5, `alm_min` out 6: stored alarm time.

## Operation
- Press event: a 0→1 transition of a button level. Exactly one event per press, however long the button is held.
- States, with the `mode` encoding: RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4.
- MODE event transitions:
  - RUN→SET_HR: copy `cur_hr`/`cur_min` into `set_hr`/`set_min`.
  - SET_HR→SET_MIN.
  - SET_MIN→ALM_HR: pulse `time_load` for one cycle.
  - ALM_HR→ALM_MIN.
  - ALM_MIN→RUN.
- UP/DOWN events:
  - SET_HR: `set_hr` ±1, modulo 24.
  - SET_MIN: `set_min` ±1, modulo 60.
  - ALM_HR: `alm_hr` ±1, modulo 24.
  - ALM_MIN: `alm_min` ±1, modulo 60.
  - RUN: ignored.
- Wrap-around: 23+1→0, 0−1→23, 59+1→0, 0−1→59. No intermediate value ever exceeds the field range.
- Simultaneous events:
  - MODE together with UP/DOWN: MODE wins and UP/DOWN is discarded.
  - UP and DOWN in the same cycle: both are discarded.
- Timeout: an idle counter clears on any event. When it reaches `TIMEOUT_CYC` in any set state, the FSM returns to RUN.
  - From SET_HR/SET_MIN: no `time_load`, edits discarded.
  - From ALM_HR/ALM_MIN: alarm edits already made are kept.
- Blink outputs:
  - `blink_hr` = 1 in SET_HR or ALM_HR.
  - `blink_min` = 1 in SET_MIN or ALM_MIN.
  - Both 0 in RUN.

## Timing
- Reset values: state RUN (`mode`=0); `set_hr`, `set_min`, `alm_hr`, `alm_min` all 0; `time_load`=0; blink outputs 0; idle/repeat counters 0; edge history 0.
  - Consequence: a button already held at reset release produces no event.
- Latency:
  - A level first sampled high at edge t produces an event in the cycle after edge t.
  - Its effect (state, field or `time_load`) is registered at edge t+1 and visible after it.
- `time_load` is high for exactly the one cycle following the SET_MIN→ALM_HR transition edge. `set_hr`/`set_min` are stable during that cycle.
- Reset mid-operation returns everything to reset values immediately and discards any pending edit. No `time_load` is issued.

## Configuration
- `AUTO_REPEAT_EN` defined:
  - After UP or DOWN has been held for `HOLD_CYC` cycles counted from its press event, a repeat step is generated.
  - Further steps follow every `REPEAT_CYC` cycles while the button stays held.
  - A repeat step behaves exactly like a press event, including clearing the idle counter.
  - Releasing the button, or a MODE event, resets the repeat counter.
- `AUTO_REPEAT_EN` undefined: one step per press only. Repeat counter logic is absent and `HOLD_CYC`/`REPEAT_CYC` are unused.

## Structure
- Shared package `alarm_pkg`:
  - State encoding constants RUN..ALM_MIN.
  - `HR_MAX`=23, `MIN_MAX`=59.
  - Field widths 5/6.
- One sub-module, `btn_pulse`, instantiated three times: level in, single-cycle event out, active-low async reset, history cleared at reset.
- Auto-repeat and timeout counters live in the top module.

## Test plan
- Reset, then press MODE with `cur_hr`=13, `cur_min`=45 → `mode`=1, `set_hr`=13, `set_min`=45, `blink_hr`=1.
- In SET_HR with `set_hr`=23, press UP → 0; press DOWN twice → 22. In SET_MIN with `set_min`=0, press DOWN → 59.
- Full sequence MODE×3 with edits to 07:30 → `time_load` high exactly one cycle with `set_hr`=7, `set_min`=30, `mode`=3. MODE×2 more → RUN, and the alarm edits are held in `alm_hr`/`alm_min`.
- MODE and UP rising in the same cycle while in SET_HR → `mode`=2, `set_hr` unchanged. UP and DOWN together in SET_MIN → no change.
- In SET_MIN, no events for `TIMEOUT_CYC` cycles (bench sets it to 50) → `mode`=0, no `time_load`. Separately, assert reset while in ALM_HR → all outputs back to reset values.
- With `AUTO_REPEAT_EN` and bench values `HOLD_CYC`=20, `REPEAT_CYC`=5: hold UP for 40 cycles in ALM_MIN starting at 0 → `alm_min`=5 (1 press + 4 repeats).

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock setting controller: mode encoding,
// field widths/limits and the modulo step helper used for every field.
package alarm_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        ALM_HR  = 3'd3,
        ALM_MIN = 3'd4
    } mode_e;

    // One step up or down with wrap; hour fields are passed zero-extended.
    function automatic logic [MIN_W-1:0] step_wrap(
        input logic [MIN_W-1:0] val,
        input logic [MIN_W-1:0] max_val,
        input logic             up
    );
        if (up)
            return (val >= max_val) ? '0 : val + 1'b1;
        else
            return (val == '0) ? max_val : val - 1'b1;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Converts a synchronized button level into a registered single-cycle press
// event; a level already high when reset releases is not treated as a press.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic hist_reg;
    logic armed_reg;
    logic pulse_reg;

    // armed_reg suppresses the first sample so a button held through reset is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg  <= 1'b0;
            armed_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            hist_reg  <= level;
            armed_reg <= 1'b1;
            pulse_reg <= armed_reg & level & ~hist_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm clock user-setting controller: button events drive the time/alarm set
// FSM. Optional auto-repeat on held UP/DOWN is enabled by defining AUTO_REPEAT_EN.
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 30_000_000,
    parameter int HOLD_CYC    = 10_000_000,
    parameter int REPEAT_CYC  = 2_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    output logic [2:0]       mode,
    output logic             blink_hr,
    output logic             blink_min,
    output logic [HR_W-1:0]  set_hr,
    output logic [MIN_W-1:0] set_min,
    output logic             time_load,
    output logic [HR_W-1:0]  alm_hr,
    output logic [MIN_W-1:0] alm_min
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0] btn_level;
    logic [2:0] btn_evt;

    assign btn_level = {btn_down, btn_up, btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            btn_pulse u_pulse (
                .clk   (clk),
                .rst   (rst),
                .level (btn_level[gi]),
                .pulse (btn_evt[gi])
            );
        end
    endgenerate

    logic evt_mode;
    logic rep_up;
    logic rep_down;

    assign evt_mode = btn_evt[0];

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_reg;
    logic             rep_phase_reg;
    logic             held_up;
    logic             held_down;
    logic             rep_hit;

    assign held_up   = btn_up & ~btn_down;
    assign held_down = btn_down & ~btn_up;

    // rep_cnt_reg equals cycles elapsed since the press (or last repeat); zero means idle.
    assign rep_hit = (held_up | held_down) && (rep_cnt_reg != '0) &&
                     (rep_cnt_reg == (rep_phase_reg ? REP_W'(REPEAT_CYC) : REP_W'(HOLD_CYC)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b0;
        end else if (evt_mode || !(held_up || held_down)) begin
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b0;
        end else if (btn_evt[1] || btn_evt[2]) begin
            rep_cnt_reg   <= REP_W'(1);
            rep_phase_reg <= 1'b0;
        end else if (rep_hit) begin
            rep_cnt_reg   <= REP_W'(1);
            rep_phase_reg <= 1'b1;
        end else if (rep_cnt_reg != '0) begin
            rep_cnt_reg   <= rep_cnt_reg + 1'b1;
        end
    end

    assign rep_up   = rep_hit & held_up;
    assign rep_down = rep_hit & held_down;
`else
    assign rep_up   = 1'b0;
    assign rep_down = 1'b0;
`endif

    logic step_up;
    logic step_down;
    logic step_any;
    logic any_evt;

    assign step_up   = btn_evt[1] | rep_up;
    assign step_down = btn_evt[2] | rep_down;
    assign step_any  = (step_up ^ step_down) & ~evt_mode;
    assign any_evt   = evt_mode | step_up | step_down;

    mode_e             state_reg;
    logic [HR_W-1:0]   set_hr_reg;
    logic [MIN_W-1:0]  set_min_reg;
    logic [HR_W-1:0]   alm_hr_reg;
    logic [MIN_W-1:0]  alm_min_reg;
    logic              time_load_reg;
    logic              blink_hr_reg;
    logic              blink_min_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;

    logic [MIN_W-1:0] set_hr_next;
    logic [MIN_W-1:0] set_min_next;
    logic [MIN_W-1:0] alm_hr_next;
    logic [MIN_W-1:0] alm_min_next;
    logic             timeout;

    assign set_hr_next  = step_wrap({1'b0, set_hr_reg}, {1'b0, HR_MAX}, step_up);
    assign set_min_next = step_wrap(set_min_reg, MIN_MAX, step_up);
    assign alm_hr_next  = step_wrap({1'b0, alm_hr_reg}, {1'b0, HR_MAX}, step_up);
    assign alm_min_next = step_wrap(alm_min_reg, MIN_MAX, step_up);

    assign timeout = (state_reg != RUN) && !any_evt &&
                     (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            set_hr_reg    <= '0;
            set_min_reg   <= '0;
            alm_hr_reg    <= '0;
            alm_min_reg   <= '0;
            time_load_reg <= 1'b0;
            blink_hr_reg  <= 1'b0;
            blink_min_reg <= 1'b0;
            idle_cnt_reg  <= '0;
        end else begin
            time_load_reg <= 1'b0;

            if (state_reg == RUN || any_evt || timeout)
                idle_cnt_reg <= '0;
            else
                idle_cnt_reg <= idle_cnt_reg + 1'b1;

            if (evt_mode) begin
                case (state_reg)
                    RUN: begin
                        state_reg     <= SET_HR;
                        set_hr_reg    <= cur_hr;
                        set_min_reg   <= cur_min;
                        blink_hr_reg  <= 1'b1;
                        blink_min_reg <= 1'b0;
                    end
                    SET_HR: begin
                        state_reg     <= SET_MIN;
                        blink_hr_reg  <= 1'b0;
                        blink_min_reg <= 1'b1;
                    end
                    SET_MIN: begin
                        state_reg     <= ALM_HR;
                        time_load_reg <= 1'b1;
                        blink_hr_reg  <= 1'b1;
                        blink_min_reg <= 1'b0;
                    end
                    ALM_HR: begin
                        state_reg     <= ALM_MIN;
                        blink_hr_reg  <= 1'b0;
                        blink_min_reg <= 1'b1;
                    end
                    default: begin
                        state_reg     <= RUN;
                        blink_hr_reg  <= 1'b0;
                        blink_min_reg <= 1'b0;
                    end
                endcase
            end else if (timeout) begin
                // Abandoned edit: time edits are dropped, alarm edits stay.
                state_reg     <= RUN;
                blink_hr_reg  <= 1'b0;
                blink_min_reg <= 1'b0;
            end else if (step_any) begin
                case (state_reg)
                    SET_HR:  set_hr_reg  <= set_hr_next[HR_W-1:0];
                    SET_MIN: set_min_reg <= set_min_next;
                    ALM_HR:  alm_hr_reg  <= alm_hr_next[HR_W-1:0];
                    ALM_MIN: alm_min_reg <= alm_min_next;
                    default: ;
                endcase
            end
        end
    end

    assign mode      = state_reg;
    assign blink_hr  = blink_hr_reg;
    assign blink_min = blink_min_reg;
    assign set_hr    = set_hr_reg;
    assign set_min   = set_min_reg;
    assign time_load = time_load_reg;
    assign alm_hr    = alm_hr_reg;
    assign alm_min   = alm_min_reg;

endmodule
